// File: rtl/prbs_pkg.sv
// prbs_pkg: shared constants, FSM state type and LFSR helpers for the
// PRBS9 transmitter and any checker-side regenerator.
package prbs_pkg;

    localparam int         PRBS9_LEN          = 511;
    localparam int         PRBS9_TAP_A        = 8;
    localparam int         PRBS9_TAP_B        = 4;
    localparam logic [8:0] PRBS9_LOCKUP_SEED  = 9'h1FF;
    localparam logic [8:0] PRBS9_DEFAULT_SEED = 9'h1AA;

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } prbs_state_t;

    // One Fibonacci step of x^9 + x^5 + 1; the output bit is the MSB.
    function automatic logic [8:0] prbs9_next(input logic [8:0] s);
        return {s[7:0], s[PRBS9_TAP_A] ^ s[PRBS9_TAP_B]};
    endfunction

    // An all-zero LFSR never leaves zero, so it is replaced on load.
    function automatic logic [8:0] prbs9_guard(input logic [8:0] s);
        return (s == 9'd0) ? PRBS9_LOCKUP_SEED : s;
    endfunction

endpackage

// File: rtl/prbs9_tx_if.sv
// prbs9_tx_if: symbol and BER-reference output bundle of prbs9_tx.
// master = transmitter, slave = TX filter / BER checker side.
interface prbs9_tx_if #(
    parameter int NB_OUTPUT = 8
);
    logic signed [NB_OUTPUT-1:0] o_symbol;
    logic                        o_bit;
    logic                        o_bit_valid;
    logic                        o_period_start;
    logic                        o_err_injected;

    modport master (
        output o_symbol, o_bit, o_bit_valid, o_period_start, o_err_injected
    );

    modport slave (
        input  o_symbol, o_bit, o_bit_valid, o_period_start, o_err_injected
    );
endinterface

// File: rtl/prbs9_lfsr.sv
// prbs9_lfsr: PRBS9 state register (x^9 + x^5 + 1, Fibonacci) with
// synchronous reset to SEED, lockup-guarded load, and step enable.
// Shared between the transmitter and the checker's reference generator.
module prbs9_lfsr
    import prbs_pkg::*;
#(
    parameter logic [8:0] SEED = PRBS9_DEFAULT_SEED
) (
    input  logic       clock,
    input  logic       i_reset,
    input  logic       i_step,
    input  logic       i_load,
    input  logic [8:0] i_seed,
    output logic [8:0] o_state
);

    logic [8:0] r_lfsr;

    // Reset beats load beats step.
    always_ff @(posedge clock) begin
        if (i_reset)
            r_lfsr <= SEED;
        else if (i_load)
            r_lfsr <= prbs9_guard(i_seed);
        else if (i_step)
            r_lfsr <= prbs9_next(r_lfsr);
    end

    assign o_state = r_lfsr;

endmodule

// File: rtl/prbs9_tx.sv
// prbs9_tx: PRBS9 pattern transmitter. Emits one bit every N_PHASES enabled
// clocks as an antipodal zero-stuffed symbol plus an unmapped reference bit.
// Optional feature macro: PRBS_ERR_INJ_EN (adds i_err_inject, single-symbol
// sign inversion for BER checker self-test).
module prbs9_tx
    import prbs_pkg::*;
#(
    parameter int         NB_OUTPUT  = 8,
    parameter int         NBF_OUTPUT = 7,
    parameter int         N_PHASES   = 4,
    parameter int         NB_PHASE   = 2,
    parameter logic [8:0] SEED       = PRBS9_DEFAULT_SEED
) (
    input  logic        clock,
    input  logic        i_reset,
    input  logic        i_enable,
    input  logic        i_seed_load,
    input  logic [8:0]  i_seed,
`ifdef PRBS_ERR_INJ_EN
    input  logic        i_err_inject,
`endif
    prbs9_tx_if.master  tx
);

    localparam logic signed [NB_OUTPUT-1:0] SYM_POS     = NB_OUTPUT'((2**NBF_OUTPUT) - 1);
    localparam logic signed [NB_OUTPUT-1:0] SYM_NEG     = -SYM_POS;
    localparam logic [NB_PHASE-1:0]         PHASE_LAST  = NB_PHASE'(N_PHASES - 1);
    localparam logic [8:0]                  BITIDX_LAST = 9'(PRBS9_LEN - 1);

    prbs_state_t                 state, nxt_state;
    logic [NB_PHASE-1:0]         r_phase, nxt_phase;
    logic [8:0]                  r_bitidx, nxt_bitidx;
    logic [8:0]                  lfsr_state;
    logic                        lfsr_load, emit, inject;
    logic signed [NB_OUTPUT-1:0] nxt_symbol;
    logic                        nxt_bit, nxt_valid, nxt_ps, nxt_err;
    logic [7:0]                  lfsr_unused;

    // A seed load acts as its own LOAD cycle: the following enabled cycle
    // emits the first bit of the new seed.
    assign lfsr_load = i_enable & i_seed_load;
    assign emit      = i_enable & ~i_seed_load & (state == RUN) & (r_phase == '0);
    assign lfsr_unused = lfsr_state[7:0];

    prbs9_lfsr #(.SEED(SEED)) u_lfsr (
        .clock   (clock),
        .i_reset (i_reset),
        .i_step  (emit),
        .i_load  (lfsr_load),
        .i_seed  (i_seed),
        .o_state (lfsr_state)
    );

`ifdef PRBS_ERR_INJ_EN
    logic r_err_pend;

    // Pulses coalesce into one pending error, consumed by the next emission.
    always_ff @(posedge clock) begin
        if (i_reset)
            r_err_pend <= 1'b0;
        else if (lfsr_load || emit)
            r_err_pend <= 1'b0;
        else if (i_err_inject)
            r_err_pend <= 1'b1;
    end

    assign inject = emit & (r_err_pend | i_err_inject);
`else
    assign inject = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clock) begin
        if (i_reset)
            state <= LOAD;
        else
            state <= nxt_state;
    end

    // Next state, counters and registered output values.
    always_comb begin
        nxt_state  = state;
        nxt_phase  = r_phase;
        nxt_bitidx = r_bitidx;
        nxt_symbol = tx.o_symbol;
        nxt_bit    = tx.o_bit;
        nxt_valid  = 1'b0;
        nxt_ps     = 1'b0;
        nxt_err    = 1'b0;
        if (i_enable) begin
            nxt_symbol = '0;
            if (i_seed_load) begin
                nxt_state  = RUN;
                nxt_phase  = '0;
                nxt_bitidx = '0;
            end else begin
                case (state)
                    LOAD: nxt_state = RUN;
                    RUN: begin
                        nxt_phase = (r_phase == PHASE_LAST) ? '0 : r_phase + 1'b1;
                        if (emit) begin
                            nxt_bit    = lfsr_state[PRBS9_TAP_A];
                            nxt_valid  = 1'b1;
                            nxt_ps     = (r_bitidx == '0);
                            nxt_err    = inject;
                            nxt_symbol = (lfsr_state[PRBS9_TAP_A] ^ inject) ? SYM_POS : SYM_NEG;
                            nxt_bitidx = (r_bitidx == BITIDX_LAST) ? '0 : r_bitidx + 9'd1;
                        end
                    end
                    default: nxt_state = LOAD;
                endcase
            end
        end
    end

    // Counters and output registers.
    always_ff @(posedge clock) begin
        if (i_reset) begin
            r_phase           <= '0;
            r_bitidx          <= '0;
            tx.o_symbol       <= '0;
            tx.o_bit          <= 1'b0;
            tx.o_bit_valid    <= 1'b0;
            tx.o_period_start <= 1'b0;
            tx.o_err_injected <= 1'b0;
        end else begin
            r_phase           <= nxt_phase;
            r_bitidx          <= nxt_bitidx;
            tx.o_symbol       <= nxt_symbol;
            tx.o_bit          <= nxt_bit;
            tx.o_bit_valid    <= nxt_valid;
            tx.o_period_start <= nxt_ps;
            tx.o_err_injected <= nxt_err;
        end
    end

endmodule

// File: tb/tb_prbs9_tx.sv
// tb_prbs9_tx: directed self-checking bench for prbs9_tx (defaults).
// Error-injection checks are built only when PRBS_ERR_INJ_EN is defined.
module tb_prbs9_tx;
    import prbs_pkg::*;

    logic       clock = 1'b0;
    logic       i_reset, i_enable, i_seed_load;
    logic [8:0] i_seed;
`ifdef PRBS_ERR_INJ_EN
    logic       i_err_inject;
`endif

    prbs9_tx_if #(.NB_OUTPUT(8)) tx_if ();

    prbs9_tx #(
        .NB_OUTPUT(8), .NBF_OUTPUT(7), .N_PHASES(4), .NB_PHASE(2), .SEED(9'h1AA)
    ) dut (
        .clock        (clock),
        .i_reset      (i_reset),
        .i_enable     (i_enable),
        .i_seed_load  (i_seed_load),
        .i_seed       (i_seed),
`ifdef PRBS_ERR_INJ_EN
        .i_err_inject (i_err_inject),
`endif
        .tx           (tx_if)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Captured strobes and running violation counters
    logic       bits_q[$];
    logic [7:0] sym_q[$];
    logic       ps_q[$];
    int         gap_q[$];
    logic       ref_q[$];
    int         en_since, zero_viol, hold_viol, err_cnt;
    logic [7:0] prev_sym;
    logic       prev_bit;

    task automatic clear_q();
        bits_q.delete(); sym_q.delete(); ps_q.delete(); gap_q.delete();
        en_since = 0; zero_viol = 0; hold_viol = 0;
    endtask

    task automatic step(input logic en);
        prev_sym = tx_if.o_symbol;
        prev_bit = tx_if.o_bit;
        i_enable = en;
        @(posedge clock);
        #1;
        if (en) en_since++;
        if (tx_if.o_err_injected) err_cnt++;
        if (tx_if.o_bit_valid) begin
            bits_q.push_back(tx_if.o_bit);
            sym_q.push_back(tx_if.o_symbol);
            ps_q.push_back(tx_if.o_period_start);
            gap_q.push_back(en_since);
            en_since = 0;
        end else if (en && (tx_if.o_symbol != 8'h00 || tx_if.o_period_start || tx_if.o_err_injected))
            zero_viol++;
        if (!en && (tx_if.o_symbol !== prev_sym || tx_if.o_bit !== prev_bit ||
                    tx_if.o_bit_valid || tx_if.o_period_start))
            hold_viol++;
    endtask

    task automatic run_bits(input string tag, input int n, input bit rand_en, input int budget);
        int cyc = 0;
        while (bits_q.size() < n && cyc < budget) begin
            step(rand_en ? 1'($urandom_range(0, 1)) : 1'b1);
            cyc++;
        end
        chk({tag, "_budget"}, 32'(bits_q.size() >= n), 32'd1);
    endtask

    task automatic gen_ref(input logic [8:0] seed, input int n);
        logic [8:0] l;
        l = seed;
        ref_q.delete();
        for (int i = 0; i < n; i++) begin
            ref_q.push_back(l[8]);
            l = {l[7:0], l[8] ^ l[4]};
        end
    endtask

    task automatic cmp_ref(input string tag, input logic [8:0] seed, input int n);
        int bm = 0, sm = 0, gm = 0;
        gen_ref(seed, n);
        for (int i = 0; i < n && i < bits_q.size(); i++) begin
            if (bits_q[i] !== ref_q[i]) bm++;
            if (sym_q[i] !== (ref_q[i] ? 8'h7F : 8'h81)) sm++;
            if (i > 0 && gap_q[i] != 4) gm++;
        end
        chk({tag, "_bits"}, bm, 0);
        chk({tag, "_syms"}, sm, 0);
        chk({tag, "_gaps"}, gm, 0);
    endtask

    initial begin
        logic [8:0] exp9;
        logic [7:0] exp_sym[9];
        int         pm, pc;
        exp9 = 9'b1_1010_1010;
        exp_sym = '{8'h7F, 8'h7F, 8'h81, 8'h7F, 8'h81, 8'h7F, 8'h81, 8'h7F, 8'h81};
        err_cnt = 0;
        i_reset = 1'b1; i_enable = 1'b1; i_seed_load = 1'b0; i_seed = 9'd0;
`ifdef PRBS_ERR_INJ_EN
        i_err_inject = 1'b0;
`endif
        clear_q();
        repeat (3) step(1'b1);
        chk("rst_symbol", tx_if.o_symbol, 8'h00);
        chk("rst_bit", tx_if.o_bit, 0);
        chk("rst_valid", tx_if.o_bit_valid, 0);
        chk("rst_pstart", tx_if.o_period_start, 0);
        chk("rst_err", tx_if.o_err_injected, 0);

        // Continuous run from SEED
        i_reset = 1'b0;
        clear_q();
        step(1'b1);
        chk("load_no_strobe", tx_if.o_bit_valid, 0);
        step(1'b1);
        chk("first_valid", tx_if.o_bit_valid, 1);
        chk("first_bit", tx_if.o_bit, 1);
        chk("first_symbol", tx_if.o_symbol, 8'h7F);
        chk("first_pstart", tx_if.o_period_start, 1);
        run_bits("cont", 1100, 1'b0, 1100 * 4 + 50);
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("hand_bit%0d", i), bits_q[i], exp9[8-i]);
            chk($sformatf("hand_sym%0d", i), sym_q[i], exp_sym[i]);
        end
        cmp_ref("cont", 9'h1AA, 1100);
        pm = 0; pc = 0;
        for (int k = 0; k + 511 < 1100; k++)
            if (bits_q[k+511] !== bits_q[k]) pm++;
        for (int k = 0; k < 1100; k++)
            if (ps_q[k]) pc++;
        chk("period_511", pm, 0);
        chk("pstart_count", pc, 3);
        chk("pstart_b0", ps_q[0], 1);
        chk("pstart_b511", ps_q[511], 1);
        chk("pstart_b1022", ps_q[1022], 1);
        chk("zero_stuff", zero_viol, 0);

        // Reset on an emission cycle: last step was a strobe, so 3 more
        // enabled cycles bring the phase back to 0.
        repeat (3) step(1'b1);
        i_reset = 1'b1;
        step(1'b1);
        chk("rst_emit_valid", tx_if.o_bit_valid, 0);
        chk("rst_emit_symbol", tx_if.o_symbol, 8'h00);
        i_reset = 1'b0;
        clear_q();
        run_bits("rst_emit", 9, 1'b0, 60);
        cmp_ref("rst_emit", 9'h1AA, 9);
        chk("rst_emit_pstart", ps_q[0], 1);
        chk("rst_emit_latency", gap_q[0], 2);

        // Random enable: same sequence, gaps counted in enabled cycles
        i_reset = 1'b1;
        step(1'b1);
        i_reset = 1'b0;
        clear_q();
        run_bits("toggle", 120, 1'b1, 3000);
        cmp_ref("toggle", 9'h1AA, 120);
        chk("toggle_hold", hold_viol, 0);
        chk("toggle_zero", zero_viol, 0);

        // Seed load of zero falls back to the lockup seed
        step(1'b1);
        step(1'b1);
        i_seed_load = 1'b1; i_seed = 9'd0;
        step(1'b1);
        i_seed_load = 1'b0;
        chk("sload_valid", tx_if.o_bit_valid, 0);
        chk("sload_symbol", tx_if.o_symbol, 8'h00);
        clear_q();
        run_bits("sload", 9, 1'b0, 60);
        cmp_ref("sload", 9'h1FF, 9);
        chk("sload_pstart", ps_q[0], 1);
        chk("sload_latency", gap_q[0], 1);

`ifdef PRBS_ERR_INJ_EN
        // Two pulses before one strobe produce exactly one inverted symbol
        step(1'b1);
        i_err_inject = 1'b1;
        step(1'b1);
        step(1'b1);
        i_err_inject = 1'b0;
        step(1'b1);
        gen_ref(9'h1FF, 11);
        chk("inj_valid", tx_if.o_bit_valid, 1);
        chk("inj_flag", tx_if.o_err_injected, 1);
        chk("inj_bit", tx_if.o_bit, ref_q[9]);
        chk("inj_symbol", tx_if.o_symbol, ref_q[9] ? 8'h81 : 8'h7F);
        run_bits("inj", 11, 1'b0, 60);
        chk("inj_next_symbol", sym_q[10], ref_q[10] ? 8'h7F : 8'h81);
        chk("inj_count", err_cnt, 1);
`else
        chk("no_inj_flag", err_cnt, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prbs9_tx.md
# prbs9_tx

PRBS9 test-pattern transmitter that feeds the TX pulse-shaping filter and drives the BER checker's reference inputs. One PRBS9 bit is produced every N_PHASES enabled clocks. Each bit is mapped to a signed antipodal symbol and zero-stuffed to the oversampled rate. The same bit goes out unmapped, with a strobe, as the BER reference stream (`i_PRBS_in` / `i_latreg_enable` on the checker).

## Interface
- NB_OUTPUT, 8, width of signed output symbol
- NBF_OUTPUT, 7, fractional bits of output symbol
- N_PHASES, 4, oversampling factor (enabled clocks per bit), ≥2
- NB_PHASE, 2, phase counter width, = clog2(N_PHASES)
- SEED, 9'h1AA, LFSR reset value, must be nonzero
- clock  in  1  system clock; one clock domain
- i_reset  in  1  synchronous, active-high reset
- i_enable  in  1  clock enable; all state holds when low
- i_seed_load  in  1  load i_seed into LFSR, restart phase/bit counters
- i_seed  in  9  seed for i_seed_load
- o_symbol  out  NB_OUTPUT signed  upsampled symbol to TX filter
- o_bit  out  1  reference PRBS bit
- o_bit_valid  out  1  one-cycle strobe, o_bit is new
- o_period_start  out  1  high with o_bit_valid on bit index 0 of the 511-bit period
- o_err_injected  out  1  high with o_bit_valid when that bit's symbol was inverted (only with PRBS_ERR_INJ_EN)

## Operation
- LFSR: x^9 + x^5 + 1, Fibonacci. Output bit = lfsr[8]. Next lfsr = {lfsr[7:0], lfsr[8]^lfsr[4]}. Period is 511.
- Phase counter r_phase runs 0..N_PHASES-1 and wraps. It advances only when i_enable=1.
- Bit counter r_bitidx runs 0..510 and wraps at 510→0. It advances on each emitted bit.
- Emission cycle (i_enable=1, r_phase==0):
  - o_bit ← lfsr[8]; o_bit_valid ← 1.
  - o_symbol ← +(2^NBF_OUTPUT − 1) for bit 1 (8'sh7F at defaults), −(2^NBF_OUTPUT − 1) for bit 0 (8'sh81).
  - o_period_start ← (r_bitidx==0).
  - LFSR steps; r_bitidx advances.
- Other enabled cycles: o_symbol ← 0 (zero-stuffing); o_bit_valid, o_period_start, o_err_injected ← 0; o_bit holds.
- i_enable=0: LFSR, counters, o_symbol and o_bit hold; all strobes ← 0.
- i_seed_load (with i_enable=1):
  - lfsr ← i_seed, or 9'h1FF if i_seed==0 (lockup guard).
  - r_phase ← 0; r_bitidx ← 0.
  - Outputs as a non-emission cycle.
  - The next enabled cycle emits lfsr[8] of the new seed with o_period_start=1.
  - Priority: i_reset > i_seed_load > normal.
- Two-state FSM: LOAD (entered on reset or seed load; lasts one enabled cycle, no emission) → RUN. RUN emits per the rules above.

## Timing
- Reset values: o_symbol=0, o_bit=0, o_bit_valid=0, o_period_start=0, o_err_injected=0, lfsr=SEED, r_phase=0, r_bitidx=0, state=LOAD.
- After reset deasserts, the first enabled cycle is LOAD. The first o_bit_valid is registered on the 2nd enabled cycle and is visible the following cycle.
- All outputs are registered with 1-cycle latency from the emission decision. o_symbol nonzero and o_bit_valid are coincident.
- Strobe spacing: exactly N_PHASES enabled cycles. Disabled cycles stretch spacing but never drop or duplicate a bit.
- o_period_start spacing: 511·N_PHASES enabled cycles (2044 at defaults).
- Reset mid-period: aborts immediately. The sequence restarts from SEED with no partial symbol.

## Configuration
- Macro: PRBS_ERR_INJ_EN.
- Defined: adds input i_err_inject (1 bit).
  - A pulse arms a pending flag.
  - The next emitted symbol (or the same cycle's, if it is an emission cycle) is sign-inverted. o_bit stays uncorrupted.
  - o_err_injected=1 on that strobe; the flag clears.
  - Pulses while pending coalesce into one error.
  - Reset and seed load clear the flag.
- Undefined: no i_err_inject port. o_err_injected is tied 0. No flag register.

## Structure
- Package prbs_pkg holds:
  - PRBS9_LEN=511, PRBS9_TAP_A=8, PRBS9_TAP_B=4
  - PRBS9_LOCKUP_SEED=9'h1FF, default SEED
  - state enum {LOAD, RUN}
- Sub-module prbs9_lfsr (clock, i_reset, i_step, i_load, i_seed → o_state[8:0]). The same sub-module is reusable on the checker side to regenerate the reference. The top holds the counters, FSM, mapper and injection logic.

## Test plan
- Reset, SEED=9'h1AA, i_enable=1 always → first 9 o_bit values on o_bit_valid = 1,1,0,1,0,1,0,1,0; o_symbol = 7F,7F,81,7F,81,7F,81,7F,81 with 3 zero cycles between each.
- Run 1100 bits → bit k+511 == bit k for all k; o_period_start every 2044 cycles, first on bit 0.
- Toggle i_enable with random 50% duty → bit sequence identical to continuous run; strobe gaps exactly 4 enabled cycles.
- i_seed_load with i_seed=0 → LFSR loads 9'h1FF; next 9 bits all 1; o_period_start on the first.
- PRBS_ERR_INJ_EN: i_err_inject pulsed twice during phase 2 → exactly one inverted symbol at the next strobe, o_bit correct, o_err_injected=1 once. Loopback into the BER checker shows one error in that 511 window.
- i_reset asserted on an emission cycle → no strobe the next cycle; sequence restarts from 9'h1AA.
